overlay_stream_fetch: RTL and testbench
=======================================

// Module: overlay_stream_fetch
// PURPOSE
//  Streams the full-frame RGBA4444 overlay image from SDRAM to the pixel compositor, one pixel per ce_pix.
//  Issues burst reads into a prefetch FIFO. Restarts at base_addr on every vsync rising edge.
//  Flags underflow when a displayed pixel is not yet fetched.
//  Sits between the sdram controller and the overlay alpha-blend/tint path.
// PARAMETERS
//  ADDR_W      25  memory byte-address width
//  DATA_W      16  memory word width = one pixel, {a,b,g,r} 4 bits each
//  FIFO_DEPTH  16  prefetch FIFO entries (power of 2, >= 2*BURST_LEN)
//  BURST_LEN   4   words per read request (1..FIFO_DEPTH/2)
//  PIX_STRIDE  2   byte-address increment per pixel
// PORTS
//  clk         in   1       system clock, all logic rising-edge
//  reset_n     in   1       asynchronous, active-low reset
//  enable      in   1       1 = overlay loaded and in use; 0 = idle, outputs zero
//  base_addr   in   ADDR_W  byte address of pixel (0,0); sampled at frame start
//  vsync       in   1       vertical sync, rising edge = frame start
//  de          in   1       active-display pixel
//  ce_pix      in   1       pixel clock enable
//  mem_req     out  1       read request, held until mem_ack
//  mem_addr    out  ADDR_W  burst start byte address, stable while mem_req
//  mem_ack     in   1       request accepted (same cycle as mem_req high)
//  mem_valid   in   1       one read word returned
//  mem_data    in   DATA_W  read word
//  px_r,px_g,px_b,px_a out 4 each  current overlay pixel
//  px_valid    out  1       pixel came from FIFO (0 = substituted zero)
//  underflow   out  1       sticky; set on pop from empty FIFO; cleared at frame start
//  fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
// BEHAVIOUR
//  Reset: mem_req=0, mem_addr=0, px_*=0, px_valid=0, underflow=0, fifo_level=0, state IDLE.
//  Frame start (fs): vs_d registered each clk; fs = vsync & ~vs_d & enable.
//  fs effects: FIFO flushed, next_addr<=base_addr, underflow<=0.
//  FSM states:
//   IDLE  -> FETCH when enable & free >= BURST_LEN.
//   FETCH -> WAIT on mem_ack; next_addr += BURST_LEN*PIX_STRIDE, mod 2^ADDR_W.
//   WAIT  -> IDLE after BURST_LEN mem_valid words, each pushed to the FIFO.
//   DRAIN -> IDLE after the remaining words of the in-flight burst are discarded.
//  free = FIFO_DEPTH - fifo_level.
//  fs handling:
//   in WAIT: go to DRAIN; the in-flight burst's remaining words are not pushed.
//   in FETCH with no ack that cycle: drop mem_req, go IDLE, new address used.
//   in FETCH with mem_ack the same cycle: treat as WAIT (go DRAIN).
//  At most one burst outstanding. mem_req rises only in FETCH.
//  mem_addr is registered from next_addr on entry to FETCH.
//  Pop: ce_pix & de & enable.
//   Non-empty: {px_a,px_b,px_g,px_r} <= head, px_valid<=1, latency 1 clk.
//   Empty: px_*<=0, px_valid<=0, underflow<=1.
//  Hold: ce_pix & ~de: px_* hold their value.
//  Push and pop in the same clk: level unchanged, data order preserved.
//  Push and fs in the same clk: fs wins, word discarded.
//  mem_valid in IDLE/FETCH: ignored; the controller must not produce it.
//  enable=0:
//   FIFO flushed, px_*=0, px_valid=0, mem_req dropped only if not yet acked.
//   An acked burst is drained before IDLE.
//  reset_n low at any time: immediate return to reset values. In-flight data is lost.
// STRUCTURE
//  Package overlay_pkg holds:
//   fetch_state_e {IDLE,FETCH,WAIT,DRAIN};
//   typedef struct packed {logic[3:0] a,b,g,r;} argb4_t;
//   function unpack_argb4(DATA_W word).
//  Sub-module sync_fifo #(WIDTH,DEPTH):
//   flush, push, pop, dout (show-ahead), level.
//   Async active-low reset.
//  The top holds the FSM, address counter, burst word counter, vsync edge detect and output regs.
// TESTING
//  1 Reset, enable=1, base_addr=0x100, vsync pulse, memory returns addr-tagged data:
//    first mem_addr=0x100, second=0x108; FIFO fills to 16, no further req.
//  2 Stream 640 de pixels at ce_pix every 2 clk, mem latency 6:
//    px values match word order 0x100,0x102..., underflow stays 0.
//  3 Memory stalled (mem_ack=0) with FIFO empty, 3 pops:
//    px_valid=0, px_*=0, underflow=1; next vsync rise clears it.
//  4 vsync rise after 2 of 4 burst words returned:
//    2 remaining words discarded (FIFO level 0). Next mem_addr=base_addr.
//  5 base_addr=2^25-4, BURST_LEN=4: second burst address wraps to 0x0000004.
//  6 enable drops mid-WAIT: burst drained, px_*=0.
//    No mem_req until enable=1 and vsync rise; push+pop same clk keeps fifo_level constant.

Source files
------------

// File: rtl/overlay_pkg.sv
// Shared types for the overlay fetch path: FSM state encoding and RGBA4444 pixel layout.
// Latency: none (types and a combinational helper only).
// Backpressure: n/a.
package overlay_pkg;

   localparam int PIX_W = 16;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      WAIT,
      DRAIN
   } fetch_state_e;

   typedef struct packed {
      logic [3:0] a;
      logic [3:0] b;
      logic [3:0] g;
      logic [3:0] r;
   } argb4_t;

   // Memory word is {a,b,g,r} from MSB to LSB, which is exactly the struct layout.
   function automatic argb4_t unpack_argb4(input logic [PIX_W-1:0] word);
      argb4_t px;
      px.a = word[15:12];
      px.b = word[11:8];
      px.g = word[7:4];
      px.r = word[3:0];
      return px;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO with show-ahead output and synchronous flush.
// Latency: a pushed word is visible on dout the cycle after the push.
// Backpressure: push when full and pop when empty are ignored; the caller gates them via level.
module sync_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     flush,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   input  logic                     pop,
   output logic [WIDTH-1:0]         dout,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_push = push & ~flush & (level != FULL_LVL);
   assign do_pop  = pop  & ~flush & (level != '0);
   assign dout    = mem[rd_ptr];

   // Storage array: written on accepted push, no reset needed.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   // Pointers and occupancy; flush empties the FIFO in one cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         level  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

endmodule

// File: rtl/overlay_stream_fetch.sv
// Overlay stream fetch: burst-reads the RGBA4444 overlay frame from SDRAM into a prefetch FIFO, one pixel per ce_pix.
// Latency: pixel registered 1 clk after its pop; first word lands mem-latency + 2 clk after frame start.
// Backpressure: a burst is issued only when the FIFO can hold all of it; a pop from empty yields zero + sticky underflow.
module overlay_stream_fetch
   import overlay_pkg::*;
#(
   parameter int ADDR_W     = 25,
   parameter int DATA_W     = 16,
   parameter int FIFO_DEPTH = 16,
   parameter int BURST_LEN  = 4,
   parameter int PIX_STRIDE = 2
) (
   input  logic                            clk,
   input  logic                            reset_n,
   input  logic                            enable,
   input  logic [ADDR_W-1:0]               base_addr,
   input  logic                            vsync,
   input  logic                            de,
   input  logic                            ce_pix,
   output logic                            mem_req,
   output logic [ADDR_W-1:0]               mem_addr,
   input  logic                            mem_ack,
   input  logic                            mem_valid,
   input  logic [DATA_W-1:0]               mem_data,
   output logic [3:0]                      px_r,
   output logic [3:0]                      px_g,
   output logic [3:0]                      px_b,
   output logic [3:0]                      px_a,
   output logic                            px_valid,
   output logic                            underflow,
   output logic [$clog2(FIFO_DEPTH):0]     fifo_level
);

   localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
   localparam int CNT_W = $clog2(BURST_LEN) + 1;
   localparam logic [LVL_W-1:0]  FIFO_L      = LVL_W'(FIFO_DEPTH);
   localparam logic [LVL_W-1:0]  BURST_L     = LVL_W'(BURST_LEN);
   localparam logic [CNT_W-1:0]  LAST_CNT    = CNT_W'(BURST_LEN - 1);
   localparam logic [ADDR_W-1:0] BURST_BYTES = ADDR_W'(BURST_LEN * PIX_STRIDE);

   fetch_state_e       state;
   logic               vs_d;
   logic               fs;
   logic               flush;
   logic               push;
   logic               pop;
   logic               fifo_empty;
   logic               last_word;
   logic               armed;
   logic [LVL_W-1:0]   free;
   logic [ADDR_W-1:0]  next_addr;
   logic [CNT_W-1:0]   word_cnt;
   logic [DATA_W-1:0]  fifo_dout;
   argb4_t             px_q;

   assign fs         = vsync & ~vs_d & enable;
   assign flush      = fs | ~enable;
   assign push       = mem_valid & (state == WAIT) & ~flush;
   assign pop        = ce_pix & de & enable;
   assign fifo_empty = (fifo_level == '0);
   assign free       = FIFO_L - fifo_level;
   assign last_word  = mem_valid & (word_cnt == LAST_CNT);

   sync_fifo #(
      .WIDTH (DATA_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .flush   (flush),
      .push    (push),
      .din     (mem_data),
      .pop     (pop),
      .dout    (fifo_dout),
      .level   (fifo_level)
   );

   // vsync edge detector.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) vs_d <= 1'b0;
      else          vs_d <= vsync;
   end

   // Fetch FSM, address counter and burst word counter. Fetching is armed by a
   // frame start and disarmed whenever the overlay is disabled, so a re-enable
   // waits for the next frame instead of resuming at a stale address.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         mem_req   <= 1'b0;
         mem_addr  <= '0;
         next_addr <= '0;
         word_cnt  <= '0;
         armed     <= 1'b0;
      end else begin
         if (fs)           armed <= 1'b1;
         else if (!enable) armed <= 1'b0;

         if (fs)                                next_addr <= base_addr;
         else if (state == FETCH && mem_ack)    next_addr <= next_addr + BURST_BYTES;

         case (state)
            IDLE: begin
               if (enable && armed && !fs && free >= BURST_L) begin
                  state    <= FETCH;
                  mem_req  <= 1'b1;
                  mem_addr <= next_addr;
               end
            end
            FETCH: begin
               if (mem_ack) begin
                  mem_req  <= 1'b0;
                  word_cnt <= '0;
                  state    <= flush ? DRAIN : WAIT;
               end else if (flush) begin
                  mem_req <= 1'b0;
                  state   <= IDLE;
               end
            end
            WAIT: begin
               if (mem_valid) word_cnt <= word_cnt + 1'b1;
               if (last_word)  state <= IDLE;
               else if (flush) state <= DRAIN;
            end
            DRAIN: begin
               if (mem_valid) word_cnt <= word_cnt + 1'b1;
               if (last_word) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Pixel output registers and sticky underflow; frame start clears underflow.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         px_q      <= '0;
         px_valid  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (fs)                      underflow <= 1'b0;
         else if (pop && fifo_empty)  underflow <= 1'b1;

         if (!enable) begin
            px_q     <= '0;
            px_valid <= 1'b0;
         end else if (pop) begin
            if (!fifo_empty) begin
               px_q     <= unpack_argb4(fifo_dout);
               px_valid <= 1'b1;
            end else begin
               px_q     <= '0;
               px_valid <= 1'b0;
            end
         end
      end
   end

   assign px_r = px_q.r;
   assign px_g = px_q.g;
   assign px_b = px_q.b;
   assign px_a = px_q.a;

endmodule

// File: tb/tb_overlay_stream_fetch.sv
// Bench for overlay_stream_fetch: queue-level pixel model plus a bursting memory responder.
// Latency: model predicts registered outputs one clk after each driven input set.
// Backpressure: memory ack probability, latency and word gaps are varied randomly.
module tb_overlay_stream_fetch;

   localparam int AW     = 25;
   localparam int DW     = 16;
   localparam int DEPTH  = 16;
   localparam int BL     = 4;
   localparam int STRIDE = 2;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          enable;
   logic [AW-1:0] base_addr;
   logic          vsync;
   logic          de;
   logic          ce_pix;
   logic          mem_req;
   logic [AW-1:0] mem_addr;
   logic          mem_ack;
   logic          mem_valid;
   logic [DW-1:0] mem_data;
   logic [3:0]    px_r, px_g, px_b, px_a;
   logic          px_valid;
   logic          underflow;
   logic [4:0]    fifo_level;

   always #5 clk = ~clk;

   overlay_stream_fetch #(
      .ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH), .BURST_LEN(BL), .PIX_STRIDE(STRIDE)
   ) dut (
      .clk(clk), .reset_n(reset_n), .enable(enable), .base_addr(base_addr),
      .vsync(vsync), .de(de), .ce_pix(ce_pix),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
      .mem_valid(mem_valid), .mem_data(mem_data),
      .px_r(px_r), .px_g(px_g), .px_b(px_b), .px_a(px_a),
      .px_valid(px_valid), .underflow(underflow), .fifo_level(fifo_level)
   );

   int checks   = 0;
   int failures = 0;

   // Model state: pixel queue, expected outputs, frame address tracking.
   logic [15:0]   mq[$];
   logic [15:0]   exp_px    = '0;
   bit            exp_valid = 0;
   bit            exp_uf    = 0;
   bit            vs_prev   = 0;
   bit            m_armed   = 0;
   logic [AW-1:0] m_next    = '0;

   // Memory responder state.
   logic [15:0]   mem_words[$];
   logic [AW-1:0] ack_addrs[$];
   int            lat_cnt  = 0;
   bit            mem_live = 0;
   int            ack_pct  = 100;
   int            mem_lat  = 6;
   int            gap_pct  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] ack_at(input int i);
      if (i < ack_addrs.size()) return 32'(ack_addrs[i]);
      return 32'hDEAD_BEEF;
   endfunction

   function automatic logic [15:0] dut_px();
      return {px_a, px_b, px_g, px_r};
   endfunction

   // One clock: compare outputs against the model, drive the next inputs, advance the model.
   task automatic step(input bit v, input bit e, input bit d, input bit c, input logic [AW-1:0] b);
      bit            ack, mv, fs, pop;
      logic [15:0]   md;
      logic [AW-1:0] wa;
      int            pre_size;
      @(negedge clk);
      chk("px", 32'(dut_px()), 32'(exp_px));
      chk("px_valid", 32'(px_valid), 32'(exp_valid));
      chk("underflow", 32'(underflow), 32'(exp_uf));
      chk("fifo_level", 32'(fifo_level), 32'(mq.size()));
      if (mem_req) chk("req_only_when_armed", 32'(m_armed), 32'd1);

      pre_size = mem_words.size();
      ack = mem_req && ($urandom_range(99) < ack_pct);
      mv  = 0;
      md  = 16'($urandom);
      if (pre_size > 0) begin
         if (lat_cnt > 0) lat_cnt--;
         else if ($urandom_range(99) >= gap_pct) begin
            mv = 1;
            md = mem_words.pop_front();
         end
      end

      vsync = v; enable = e; de = d; ce_pix = c; base_addr = b;
      mem_ack = ack; mem_valid = mv; mem_data = md;

      fs = v && !vs_prev && e;
      vs_prev = v;
      pop = c && d && e;

      if (ack) begin
         chk("one_outstanding", 32'(pre_size), 32'd0);
         chk("mem_addr", 32'(mem_addr), 32'(m_next));
         chk("room_for_burst", 32'(mq.size() <= DEPTH - BL), 32'd1);
         ack_addrs.push_back(mem_addr);
         for (int i = 0; i < BL; i++) begin
            wa = mem_addr + AW'(STRIDE * i);
            mem_words.push_back(wa[15:0]);
         end
         lat_cnt  = mem_lat;
         mem_live = 1;
      end

      if (pop) begin
         if (mq.size() > 0) begin
            exp_px = mq.pop_front();
            exp_valid = 1;
         end else begin
            exp_px = '0;
            exp_valid = 0;
            exp_uf = 1;
         end
      end
      if (!e) begin
         exp_px = '0;
         exp_valid = 0;
      end
      if (mv && mem_live && e && !fs) mq.push_back(md);
      if (fs || !e) begin
         mq.delete();
         mem_live = 0;
      end
      if (fs) exp_uf = 0;
      if (fs)       m_next = b;
      else if (ack) m_next = m_next + AW'(BL * STRIDE);
      if (fs)      m_armed = 1;
      else if (!e) m_armed = 0;
   endtask

   logic [AW-1:0] base_next;
   int            n0, req_cnt, vs_timer, vs_hi, en_off;
   bit            done;

   initial begin
      reset_n = 0; enable = 0; base_addr = '0; vsync = 0; de = 0; ce_pix = 0;
      mem_ack = 0; mem_valid = 0; mem_data = '0;
      repeat (3) @(negedge clk);
      chk("rst_mem_req", 32'(mem_req), 32'd0);
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);
      chk("rst_px", 32'(dut_px()), 32'd0);
      chk("rst_px_valid", 32'(px_valid), 32'd0);
      chk("rst_underflow", 32'(underflow), 32'd0);
      chk("rst_level", 32'(fifo_level), 32'd0);
      reset_n = 1;

      // Frame start at 0x100, memory returns address-tagged words; FIFO fills.
      base_next = 25'h100;
      step(0, 1, 0, 0, base_next);
      step(1, 1, 0, 0, base_next);
      step(1, 1, 0, 0, base_next);
      repeat (80) step(0, 1, 0, 0, base_next);
      chk("t1_addr0", ack_at(0), 32'h100);
      chk("t1_addr1", ack_at(1), 32'h108);
      chk("t1_bursts", 32'(ack_addrs.size()), 32'd4);
      chk("t1_level_full", 32'(fifo_level), 32'd16);
      chk("t1_no_req", 32'(mem_req), 32'd0);

      // 640 displayed pixels, ce every 2 clk, lines with blanking between them.
      for (int line = 0; line < 40; line++) begin
         for (int p = 0; p < 16; p++) begin
            step(0, 1, 1, 1, base_next);
            step(0, 1, 1, 0, base_next);
            if (line == 0 && p == 0) chk("t2_first_px", 32'(dut_px()), 32'h0100);
         end
         repeat (24) begin
            step(0, 1, 0, 1, base_next);
            step(0, 1, 0, 0, base_next);
         end
      end
      chk("t2_last_px", 32'(dut_px()), 32'h05FE);
      chk("t2_last_valid", 32'(px_valid), 32'd1);
      chk("t2_no_underflow", 32'(underflow), 32'd0);

      // Memory stalled, FIFO flushed by frame start, three pops from empty.
      repeat (60) step(0, 1, 0, 0, base_next);
      ack_pct = 0;
      step(1, 1, 0, 0, base_next);
      step(1, 1, 0, 0, base_next);
      step(0, 1, 0, 0, base_next);
      repeat (3) begin
         step(0, 1, 1, 1, base_next);
         step(0, 1, 1, 0, base_next);
      end
      chk("t3_px_zero", 32'(dut_px()), 32'd0);
      chk("t3_px_invalid", 32'(px_valid), 32'd0);
      chk("t3_underflow_set", 32'(underflow), 32'd1);
      step(1, 1, 0, 0, base_next);
      step(1, 1, 0, 0, base_next);
      chk("t3_underflow_cleared", 32'(underflow), 32'd0);
      step(0, 1, 0, 0, base_next);

      // Frame start after two of four burst words: remainder discarded, restart at new base.
      ack_pct = 100;
      base_next = 25'h2000;
      done = 0;
      for (int k = 0; k < 100 && !done; k++) begin
         if (mem_words.size() == 2) begin
            step(1, 1, 0, 0, base_next);
            done = 1;
         end else step(0, 1, 0, 0, base_next);
      end
      if (!done) chk("t4_burst_timeout", 32'd0, 32'd1);
      n0 = ack_addrs.size();
      step(1, 1, 0, 0, base_next);
      step(0, 1, 0, 0, base_next);
      chk("t4_level_zero", 32'(fifo_level), 32'd0);
      for (int k = 0; k < 100 && ack_addrs.size() == n0; k++) step(0, 1, 0, 0, base_next);
      chk("t4_restart_addr", ack_at(n0), 32'h2000);

      // Address wrap at the top of the 32 MB space.
      base_next = 25'h1FF_FFFC;
      step(1, 1, 0, 0, base_next);
      n0 = ack_addrs.size();
      step(1, 1, 0, 0, base_next);
      repeat (60) step(0, 1, 0, 0, base_next);
      chk("t5_addr_top", ack_at(n0), 32'h1FF_FFFC);
      chk("t5_addr_wrap", ack_at(n0 + 1), 32'h000_0004);

      // Enable drops mid-burst; no fetch again until enabled and a new frame starts.
      done = 0;
      for (int k = 0; k < 300 && !done; k++) begin
         if (mem_words.size() == 2) begin
            step(0, 0, 0, 0, base_next);
            done = 1;
         end else step(0, 1, 1, 1, base_next);
      end
      if (!done) chk("t6_burst_timeout", 32'd0, 32'd1);
      step(0, 0, 0, 0, base_next);
      chk("t6_px_zero", 32'(dut_px()), 32'd0);
      chk("t6_px_invalid", 32'(px_valid), 32'd0);
      chk("t6_level_zero", 32'(fifo_level), 32'd0);
      req_cnt = 0;
      repeat (20) begin
         step(0, 0, 1, 1, base_next);
         if (mem_req) req_cnt++;
      end
      repeat (20) begin
         step(0, 1, 0, 0, base_next);
         if (mem_req) req_cnt++;
      end
      chk("t6_no_req_without_frame", 32'(req_cnt), 32'd0);
      n0 = ack_addrs.size();
      step(1, 1, 0, 0, base_next);
      step(1, 1, 0, 0, base_next);
      repeat (40) step(0, 1, 0, 0, base_next);
      chk("t6_req_after_vsync", 32'(ack_addrs.size() > n0), 32'd1);
      chk("t6_restart_addr", ack_at(n0), 32'h1FF_FFFC);

      // Randomized traffic: frame starts, enable drops, random pops and memory timing.
      vs_timer = 100; vs_hi = 0; en_off = 0;
      for (int n = 0; n < 4000; n++) begin
         if (n % 500 == 0) begin
            ack_pct = $urandom_range(100, 20);
            mem_lat = $urandom_range(8, 1);
            gap_pct = $urandom_range(30, 0);
         end
         if (vs_hi > 0) vs_hi--;
         else if (vs_timer == 0) begin
            vs_hi = $urandom_range(3, 1);
            vs_timer = $urandom_range(400, 150);
            base_next = AW'($urandom) & ~AW'(1);
         end else vs_timer--;
         if (en_off > 0) en_off--;
         else if ($urandom_range(599) == 0) en_off = $urandom_range(30, 3);
         step(vs_hi > 0, en_off == 0, $urandom_range(99) < 55, 1'($urandom_range(1)), base_next);
      end

      // Asynchronous reset in the middle of traffic returns everything to idle at once.
      @(negedge clk);
      #2 reset_n = 0;
      #1;
      chk("arst_mem_req", 32'(mem_req), 32'd0);
      chk("arst_mem_addr", 32'(mem_addr), 32'd0);
      chk("arst_px", 32'(dut_px()), 32'd0);
      chk("arst_px_valid", 32'(px_valid), 32'd0);
      chk("arst_underflow", 32'(underflow), 32'd0);
      chk("arst_level", 32'(fifo_level), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
